// File: rtl/ieee_conv_pkg.sv
// rtl/ieee_conv_pkg.sv - shared constants and FSM state type for the float to 8.8 converter
package ieee_conv_pkg;

  localparam int EXP_BIAS      = 127;
  localparam int EXP_FIELD_MAX = 255;
  localparam int MANT_W        = 23;
  localparam int FIX_W         = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/int_frac_converter.sv
// rtl/int_frac_converter.sv - combinational IEEE-754 single to 8.8 fixed-point core with range gating
module int_frac_converter
  import ieee_conv_pkg::*;
#(
  parameter int MAX_EXP = 7
) (
  input  logic [31:0]      op,
  output logic [FIX_W-1:0] int_part,
  output logic [FIX_W-1:0] frac_part,
  output logic             err
);

  logic [7:0]        exp_field;
  logic signed [8:0] e;
  logic [31:0]       shifted;
  logic              unused_bits;

  assign exp_field = op[30:23];

  // Hidden one sits at bit 23; shifting by e places the binary point between bits 23 and 22.
  always_comb begin
    e         = 9'({1'b0, exp_field}) - 9'(EXP_BIAS);
    err       = op[31] | e[8] | (e > $signed(9'(MAX_EXP)))
              | (exp_field == 8'(EXP_FIELD_MAX));
    shifted   = {8'd0, 1'b1, op[MANT_W-1:0]} << e[2:0];
    int_part  = err ? '0 : shifted[30:23];
    frac_part = err ? '0 : shifted[22:15];
  end

  assign unused_bits = ^{shifted[31], shifted[14:0]};

endmodule

// File: rtl/ieee_conv_arbiter.sv
// rtl/ieee_conv_arbiter.sv - round-robin two-requester front end sharing one float to 8.8 converter
module ieee_conv_arbiter
  import ieee_conv_pkg::*;
#(
  parameter int MAX_EXP = 7,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [31:0]      req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [31:0]      req1_data,
  output logic             req1_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FIX_W-1:0] out_int,
  output logic [FIX_W-1:0] out_frac,
  output logic             out_id,
  output logic             out_err,
  output logic             busy,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_cnt_clr
);

  state_t           state;
  logic [31:0]      op_q;
  logic             id_q;
  logic             last_gnt;
  logic             can_grant;
  logic             gnt;
  logic             winner;
  logic [FIX_W-1:0] conv_int;
  logic [FIX_W-1:0] conv_frac;
  logic             conv_err;

  // A grant is possible from IDLE, or from DONE in the same cycle the result is taken.
  always_comb begin
    can_grant = (state == IDLE) || ((state == DONE) && out_ready);
    gnt       = can_grant && (req0_valid || req1_valid);
    winner    = (req0_valid && req1_valid) ? ~last_gnt : req1_valid;
  end

  assign req0_ready = gnt && !winner;
  assign req1_ready = gnt && winner;
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);

  int_frac_converter #(
    .MAX_EXP(MAX_EXP)
  ) u_conv (
    .op       (op_q),
    .int_part (conv_int),
    .frac_part(conv_frac),
    .err      (conv_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= '0;
      id_q     <= 1'b0;
      last_gnt <= 1'b1;
      out_int  <= '0;
      out_frac <= '0;
      out_id   <= 1'b0;
      out_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (gnt) state <= CONV;
        CONV: begin
          state    <= DONE;
          out_int  <= conv_int;
          out_frac <= conv_frac;
          out_id   <= id_q;
          out_err  <= conv_err;
        end
        DONE: if (out_ready) state <= gnt ? CONV : IDLE;
        default: state <= IDLE;
      endcase
      if (gnt) begin
        op_q     <= winner ? req1_data : req0_data;
        id_q     <= winner;
        last_gnt <= winner;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_cnt_clr) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && out_err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: doc/ieee_conv_arbiter.md
Name: ieee_conv_arbiter

Overview:
- Two-requester front end that shares one IEEE-754 single to 8.8 fixed-point converter.
- Arbitrates round-robin, registers the operand, and range-checks it.
- Returns a tagged result through a valid/ready output with backpressure.
- Keeps a saturating error counter; sits between the float producers and downstream fixed-point consumers.

Parameters:
- MAX_EXP, 7, largest unbiased exponent accepted (legal 0..7, so the integer part fits 8 bits).
- CNT_W, 8, width of err_cnt.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operand
- req0_data  in  32  requester 0 IEEE-754 single
- req0_ready  out  1  requester 0 operand accepted this cycle
- req1_valid  in  1  requester 1 has an operand
- req1_data  in  32  requester 1 IEEE-754 single
- req1_ready  out  1  requester 1 operand accepted this cycle
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- out_int  out  8  integer part
- out_frac  out  8  fraction part
- out_id  out  1  requester that owns the result
- out_err  out  1  operand out of range; out_int/out_frac are 0
- busy  out  1  state != IDLE
- err_cnt  out  CNT_W  saturating count of errored results delivered
- err_cnt_clr  in  1  synchronous clear of err_cnt

Behaviour:
- Reset: state=IDLE; op_q=0; last_gnt=1 (requester 0 wins first); all outputs 0; readies 0.
- States:
  - IDLE: on any valid, grant, capture operand into op_q and id into id_q, go to CONV.
  - CONV: always go to DONE next edge.
  - DONE: hold results. If out_ready and a request is pending, grant/capture in the same cycle and go to CONV. If out_ready and nothing is pending, go to IDLE. If out_ready=0, stay in DONE.
- Grant rule:
  - If only one requester is valid, it wins.
  - If both are valid, the requester other than last_gnt wins.
  - last_gnt updates on every grant.
  - reqN_ready is combinational: high only in the grant cycle, only for the winner.
  - Never more than one ready per cycle.
  - The loser's valid/data must stay stable (standard valid/ready).
- Datapath:
  - Converter input is op_q; its output is registered into out_int/out_frac at the CONV->DONE edge.
  - Latency: grant at edge k gives out_valid=1 after edge k+2.
  - Peak throughput: 1 result per 2 cycles.
- Range check (on op_q, unbiased e = op_q[30:23]-127, computed 9-bit signed):
  - err = sign bit set, or e<0, or e>MAX_EXP, or exponent field 255.
  - On err: out_int=0, out_frac=0, out_err=1.
- Integer/fraction extraction: for legal e, out_int = {1, mantissa[22:23-e]} zero-extended, out_frac = mantissa[22-e:15-e]; truncation only, no rounding.
- out_valid = (state==DONE). Outputs are held stable while out_valid=1 and out_ready=0.
- err_cnt:
  - Increments on each handshake (out_valid && out_ready) with out_err=1; saturates at all-ones.
  - err_cnt_clr has priority over increment in the same cycle.
- Reset mid-operation: an in-flight operand is dropped, no result is produced, and err_cnt returns to 0.
- busy=1 in CONV and DONE.

Decomposition:
- Shared package ieee_conv_pkg:
  - constants EXP_BIAS=127, EXP_FIELD_MAX=255, MANT_W=23, FIX_W=8
  - state enum {IDLE, CONV, DONE}
- Sub-module: int_frac_converter, instantiated unchanged as the combinational core. Range gating and zeroing are done in this block.

Test Plan:
- req0=0x40490FDB alone -> req0_ready for 1 cycle; out_valid 2 cycles later; int=0x03, frac=0x24, id=0, err=0.
- req1=0x41200000 alone -> int=0x0A, frac=0x00, id=1. Then req0=0x3F800000 -> int=0x01, frac=0x00.
- Both valid continuously right after reset, out_ready=1 -> grants alternate 0,1,0,1; results every 2 cycles with matching id.
- 0xBF800000, 0x3F000000, 0x43800000, 0x7FC00000 -> each gives err=1, int=0, frac=0; err_cnt=4.
- out_ready low 5 cycles in DONE -> outputs stable, no further readies; out_ready high -> next grant in the same cycle.
- err_cnt driven to 255 then one more error -> stays 255. err_cnt_clr with a simultaneous error handshake -> 0. rst asserted in CONV -> out_valid never rises and state=IDLE.
